// File: rtl/clk_tick_pkg.sv
// clk_tick_pkg
// Shared types for the tick controller:
//   tick_mode_t  - encoding of the 2-bit mode input (HALT/RUN/STEP/BURST)
//   tick_state_t - controller states. The names carry an S_ prefix because
//                  HALT and RUN are already taken by tick_mode_t in this scope.
//   DEFAULT_SYNC_STAGES - default synchroniser depth
// Helper functions map a mode to its entry state, and a state back to the
// mode that owns it.
package clk_tick_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BURST = 2'd3
  } tick_mode_t;

  typedef enum logic [2:0] {
    S_HALT         = 3'd0,
    S_RUN          = 3'd1,
    S_STEP_IDLE    = 3'd2,
    S_STEP_ARMED   = 3'd3,
    S_BURST_IDLE   = 3'd4,
    S_BURST_ACTIVE = 3'd5
  } tick_state_t;

  // State entered when the controller switches into mode m.
  function automatic tick_state_t home_state(input tick_mode_t m);
    case (m)
      RUN:     return S_RUN;
      STEP:    return S_STEP_IDLE;
      BURST:   return S_BURST_IDLE;
      default: return S_HALT;
    endcase
  endfunction

  // Mode that a state belongs to; used to detect a mode change.
  function automatic tick_mode_t state_mode(input tick_state_t s);
    case (s)
      S_RUN:                       return RUN;
      S_STEP_IDLE, S_STEP_ARMED:   return STEP;
      S_BURST_IDLE, S_BURST_ACTIVE: return BURST;
      default:                     return HALT;
    endcase
  endfunction

endpackage

// File: rtl/clk_tick_ctrl_edge_sync.sv
// edge_sync
// Synchronises an asynchronous level into the clk_in domain and flags its
// rising edges. Reusable for any slow asynchronous input.
// Ports:
//   clk_in   - sampling clock
//   reset    - asynchronous, active-low reset (clears chain and history)
//   async_in - asynchronous input level
//   rise     - high for one clk_in cycle after the synchronised level goes 0->1
// Parameter SYNC_STAGES: synchroniser depth, legal range 2..4.
module edge_sync
  import clk_tick_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk_in,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_depth
    $error("edge_sync: SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   history;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_chain <= '0;
      history    <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
      history    <= sync_chain[SYNC_STAGES-1];
    end
  end

  // Combinational from flops only; the consumer registers it.
  assign rise = sync_chain[SYNC_STAGES-1] & ~history;

endmodule

// File: rtl/clk_tick_ctrl.sv
// clk_tick_ctrl
// Turns rising edges of the divided slow clock into single-cycle clock-enable
// pulses for the core array, gated by HALT / RUN / single-step / burst control.
// The cores stay on clk_in; slow_clk is only ever sampled.
// Ports:
//   clk_in     - system clock
//   reset      - asynchronous, active-low reset
//   slow_clk   - divided clock, asynchronous to clk_in
//   mode       - 0=HALT 1=RUN 2=STEP 3=BURST
//   step_req   - level; its rising edge arms a step or a burst
//   burst_len  - tick count for a burst, sampled when the burst is armed
//   tick_out   - one-cycle enable pulse to the cores
//   busy       - step/burst armed or in progress
//   done       - one-cycle pulse when a step/burst completes normally
//   tick_count - total ticks issued, wraps        (TICK_COUNT_EN only)
//   clr_count  - synchronous clear of tick_count  (TICK_COUNT_EN only)
// Build option: define TICK_COUNT_EN to include the tick counter and its ports.
module clk_tick_ctrl
  import clk_tick_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int BURST_W     = 16,
  parameter int COUNT_W     = 32
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               slow_clk,
  input  logic [1:0]         mode,
  input  logic               step_req,
  input  logic [BURST_W-1:0] burst_len,
  output logic               tick_out,
  output logic               busy,
  output logic               done
`ifdef TICK_COUNT_EN
  ,
  output logic [COUNT_W-1:0] tick_count,
  input  logic               clr_count
`endif
);

  if (BURST_W < 1 || COUNT_W < 1) begin : g_bad_width
    $error("clk_tick_ctrl: BURST_W and COUNT_W must be at least 1");
  end

  logic               rise;
  logic               step_prev;
  logic               step_edge;
  logic [BURST_W-1:0] remaining;
  tick_state_t        state;
  tick_mode_t         mode_req;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_in  (clk_in),
    .reset   (reset),
    .async_in(slow_clk),
    .rise    (rise)
  );

  assign mode_req  = tick_mode_t'(mode);
  assign step_edge = step_req & ~step_prev;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= S_HALT;
      remaining <= '0;
      step_prev <= 1'b0;
      tick_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      step_prev <= step_req;
      tick_out  <= 1'b0;
      done      <= 1'b0;
      if (state_mode(state) != mode_req) begin
        // Mode change aborts anything pending; a rise this cycle is dropped.
        state     <= home_state(mode_req);
        remaining <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_HALT: ;
          S_RUN: tick_out <= rise;
          S_STEP_IDLE: begin
            // A rise coincident with arming is deliberately not consumed.
            if (step_edge) begin
              state <= S_STEP_ARMED;
              busy  <= 1'b1;
            end
          end
          S_STEP_ARMED: begin
            if (rise) begin
              tick_out <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= S_STEP_IDLE;
            end
          end
          S_BURST_IDLE: begin
            if (step_edge) begin
              if (burst_len == '0) begin
                done <= 1'b1;
              end else begin
                remaining <= burst_len;
                busy      <= 1'b1;
                state     <= S_BURST_ACTIVE;
              end
            end
          end
          S_BURST_ACTIVE: begin
            if (rise) begin
              tick_out  <= 1'b1;
              remaining <= remaining - BURST_W'(1);
              if (remaining == BURST_W'(1)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_BURST_IDLE;
              end
            end
          end
          default: state <= S_HALT;
        endcase
      end
    end
  end

`ifdef TICK_COUNT_EN
  // Counts registered ticks, so it trails tick_out by one cycle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tick_count <= '0;
    end else if (clr_count) begin
      tick_count <= '0;
    end else if (tick_out) begin
      tick_count <= tick_count + COUNT_W'(1);
    end
  end
`endif

endmodule
